// File: rtl/uart_tx_periph_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// FSM state encoding, STATUS bit positions and divisor helper.
package uart_tx_periph_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned BYTE_W  = 8;

    // Register offsets, decoded from address[3:2]
    localparam logic [1:0] UartTxData  = 2'd0;
    localparam logic [1:0] UartStatus  = 2'd1;
    localparam logic [1:0] UartDivisor = 2'd2;
    localparam logic [1:0] UartCtrl    = 2'd3;

    typedef enum logic [1:0] {
        UartIdle  = 2'd0,
        UartStart = 2'd1,
        UartData  = 2'd2,
        UartStop  = 2'd3
    } uart_state_e;

    localparam int unsigned StatusFull     = 0;
    localparam int unsigned StatusEmpty    = 1;
    localparam int unsigned StatusBusy     = 2;
    localparam int unsigned StatusOverflow = 3;
    localparam int unsigned StatusCountLsb = 8;

    // A programmed divisor of zero still yields one cycle per bit
    function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: TX FIFO, divisor
// and control registers, frame serialiser and transmit-complete interrupt.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int unsigned      FIFO_DEPTH      = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chip_enable,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] address,
    input  logic [3:0]        sel,
    input  logic [DATA_W-1:0] data_input,
    output logic [DATA_W-1:0] data_output,
    output logic              tx,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    uart_state_e       state;
    uart_state_e       state_next;
    logic [DIV_W-1:0]  divisor;
    logic [DIV_W-1:0]  div_lat;
    logic [DIV_W-1:0]  timer;
    logic [BYTE_W-1:0] shift;
    logic [2:0]        bit_idx;
    logic              enable;
    logic              irq_en;
    logic              overflow;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [BYTE_W-1:0] fifo_head;

    logic [1:0]        reg_addr;
    logic              bus_wr;
    logic              bus_rd;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              bit_done;
    logic              tx_next;
    logic [DATA_W-1:0] status_word;
    logic              unused_bits;

    assign reg_addr    = address[3:2];
    assign bus_wr      = chip_enable && write_enable;
    assign bus_rd      = chip_enable && !write_enable;
    assign push_req    = bus_wr && (reg_addr == UartTxData) && (sel == 4'b1111);
    assign push_ok     = push_req && (!fifo_full || pop);
    assign bit_done    = (timer == div_lat - DIV_W'(1));
    assign unused_bits = ^{address[DATA_W-1:4], address[1:0], data_input[DATA_W-1:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (data_input[BYTE_W-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= UartIdle;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            UartIdle:  if (enable && !fifo_empty) state_next = UartStart;
            UartStart: if (bit_done) state_next = UartData;
            UartData:  if (bit_done && bit_idx == 3'd7) state_next = UartStop;
            UartStop:  if (bit_done) state_next = (enable && !fifo_empty) ? UartStart : UartIdle;
            default:   state_next = UartIdle;
        endcase
    end

    // tx_next is the line level for the cycle after the coming edge
    always_comb begin
        pop     = 1'b0;
        tx_next = 1'b1;
        case (state)
            UartIdle:  pop = enable && !fifo_empty;
            UartStart: tx_next = bit_done ? shift[0] : 1'b0;
            UartData: begin
                if (!bit_done)            tx_next = shift[bit_idx];
                else if (bit_idx != 3'd7) tx_next = shift[bit_idx + 3'd1];
            end
            UartStop:  pop = bit_done && enable && !fifo_empty;
            default:   ;
        endcase
        if (pop) tx_next = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx      <= 1'b1;
            irq     <= 1'b0;
            timer   <= '0;
            div_lat <= DIV_W'(1);
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            tx  <= tx_next;
            irq <= irq_en && fifo_empty && (state == UartIdle);
            if (pop) begin
                shift   <= fifo_head;
                div_lat <= eff_divisor(divisor);
                timer   <= '0;
                bit_idx <= '0;
            end else if (state != UartIdle) begin
                if (bit_done) begin
                    timer <= '0;
                    if (state == UartData) bit_idx <= bit_idx + 3'd1;
                end else begin
                    timer <= timer + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            divisor  <= DEFAULT_DIVISOR;
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus_wr && reg_addr == UartDivisor) begin
                if (sel[0]) divisor[7:0]  <= data_input[7:0];
                if (sel[1]) divisor[15:8] <= data_input[15:8];
            end
            if (bus_wr && reg_addr == UartCtrl && sel[0]) begin
                enable <= data_input[0];
                irq_en <= data_input[1];
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (bus_wr && reg_addr == UartStatus && data_input[StatusOverflow]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[StatusFull]              = fifo_full;
        status_word[StatusEmpty]             = fifo_empty;
        status_word[StatusBusy]              = (state != UartIdle);
        status_word[StatusOverflow]          = overflow;
        status_word[StatusCountLsb +: BYTE_W] = BYTE_W'(fifo_count);
    end

    always_comb begin
        data_output = '0;
        if (bus_rd) begin
            case (reg_addr)
                UartStatus:  data_output = status_word;
                UartDivisor: data_output = DATA_W'(divisor);
                UartCtrl:    data_output = DATA_W'({irq_en, enable});
                default:     data_output = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: a queue/waveform model predicts tx, irq and register
// reads every cycle; directed tests add literal expectations.
module tb_uart_tx_periph;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] din;
    logic [31:0] dout;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Model state: pending bytes, remaining line levels of the current frame
    logic [7:0]  q[$];
    logic        wave[$];
    logic [15:0] m_div = 16'd434;
    logic        m_en = 1'b0;
    logic        m_irq_en = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_tx = 1'b1;
    logic        m_irq = 1'b0;
    logic        m_busy = 1'b0;

    uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(16'd434)) dut (
        .clock        (clk),
        .reset        (rst),
        .chip_enable  (ce),
        .write_enable (we),
        .address      (addr),
        .sel          (sel),
        .data_input   (din),
        .data_output  (dout),
        .tx           (tx),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        case (a[3:2])
            2'd1: r = {16'h0, 8'(q.size()), 4'h0, m_ovf, m_busy, q.size() == 0, q.size() == DEPTH};
            2'd2: r = {16'h0, m_div};
            2'd3: r = {30'h0, m_irq_en, m_en};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model update on each clock edge, using pre-edge values for decisions
    always @(posedge clk) begin
        bit          do_pop;
        int          dv;
        logic [7:0]  b;
        if (rst) begin
            q.delete();
            wave.delete();
            m_div = 16'd434; m_en = 0; m_irq_en = 0; m_ovf = 0;
            m_tx = 1; m_irq = 0; m_busy = 0;
        end else begin
            m_irq  = m_irq_en && (q.size() == 0) && !m_busy;
            do_pop = (wave.size() == 0) && m_en && (q.size() != 0);
            dv     = (m_div == 0) ? 1 : int'(m_div);
            if (ce && we) begin
                case (addr[3:2])
                    2'd0: if (sel == 4'hF) begin
                        if (q.size() < DEPTH || do_pop) q.push_back(din[7:0]);
                        else m_ovf = 1;
                    end
                    2'd1: if (din[3]) m_ovf = 0;
                    2'd2: begin
                        if (sel[0]) m_div[7:0]  = din[7:0];
                        if (sel[1]) m_div[15:8] = din[15:8];
                    end
                    default: if (sel[0]) begin m_en = din[0]; m_irq_en = din[1]; end
                endcase
            end
            if (do_pop) begin
                b = q.pop_front();
                for (int j = 0; j < 10; j++)
                    for (int k = 0; k < dv; k++)
                        wave.push_back(j == 0 ? 1'b0 : (j == 9 ? 1'b1 : b[j-1]));
            end
            if (wave.size() != 0) begin m_tx = wave.pop_front(); m_busy = 1; end
            else begin m_tx = 1; m_busy = 0; end
        end
    end

    // Continuous compare of the serial line and interrupt
    always @(negedge clk) begin
        check("tx_model", tx, m_tx);
        check("irq_model", irq, m_irq);
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        ce = 1; we = 1; addr = a; din = d; sel = s;
        @(posedge clk);
        #1;
        ce = 0; we = 0; sel = 0; din = 0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1; we = 0; addr = a;
        #1;
        d = dout;
        check(name, d, exp_read(a));
        ce = 0;
    endtask

    logic [31:0] d;
    logic [41:0] s_tx, e_tx;
    logic [41:0] s_busy;
    logic [7:0]  s_cnt [42];
    logic [9:0]  pat, pat2;

    initial begin
        rst = 1; ce = 0; we = 0; addr = 0; sel = 0; din = 0;
        repeat (3) @(negedge clk);
        rst = 0;

        // Reset values
        read_chk("rst_status", 32'h4, d);  check("rst_status_lit", d, 32'h2);
        read_chk("rst_div", 32'h8, d);     check("rst_div_lit", d, 32'd434);
        read_chk("rst_ctrl", 32'hC, d);    check("rst_ctrl_lit", d, 32'h0);
        read_chk("rst_txdata", 32'h0, d);  check("rst_txdata_lit", d, 32'h0);
        check("rst_tx", tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        #1 check("dout_ce0", dout, 32'h0);
        @(negedge clk);
        ce = 1; we = 1; addr = 32'h4; din = 32'h0; sel = 4'h0;
        #1 check("dout_we1", dout, 32'h0);
        ce = 0; we = 0;

        // Single frame 0x55 at divisor 4
        bus_write(32'h8, 32'd4, 4'hF);
        bus_write(32'hC, 32'd1, 4'hF);
        bus_write(32'h0, 32'h55, 4'hF);
        for (int i = 0; i < 42; i++) begin
            read_chk("t2_status", 32'h4, d);
            s_tx[i] = tx; s_busy[i] = d[2];
        end
        pat = 10'b1010101010;
        for (int i = 0; i < 42; i++) e_tx[i] = (i >= 1 && i <= 40) ? pat[(i-1)/4] : 1'b1;
        check("t2_frame55", s_tx, e_tx);
        check("t2_busy_pre", s_busy[0], 1'b0);
        check("t2_busy_start", s_busy[1], 1'b1);
        check("t2_busy_last", s_busy[40], 1'b1);
        check("t2_busy_clear", s_busy[41], 1'b0);

        // Back-to-back frames at divisor 2
        bus_write(32'h8, 32'd2, 4'hF);
        bus_write(32'h0, 32'hA5, 4'hF);
        bus_write(32'h0, 32'h3C, 4'hF);
        for (int i = 0; i < 42; i++) begin
            read_chk("t3_status", 32'h4, d);
            s_tx[i] = tx; s_busy[i] = d[2]; s_cnt[i] = d[15:8];
        end
        pat  = {1'b1, 8'hA5, 1'b0};
        pat2 = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 42; i++)
            e_tx[i] = (i < 20) ? pat[i/2] : ((i < 40) ? pat2[(i-20)/2] : 1'b1);
        check("t3_frames", s_tx, e_tx);
        check("t3_cnt_first", s_cnt[0], 8'd1);
        check("t3_cnt_before_pop", s_cnt[19], 8'd1);
        check("t3_cnt_after_pop", s_cnt[20], 8'd0);
        check("t3_no_gap", s_busy[20], 1'b1);
        check("t3_idle", s_busy[40], 1'b0);

        // Overflow with transmitter disabled
        bus_write(32'hC, 32'd0, 4'hF);
        for (int k = 0; k < 9; k++) bus_write(32'h0, 32'(k + 1), 4'hF);
        read_chk("t4_status", 32'h4, d);   check("t4_status_lit", d, 32'h0809);
        check("t4_tx_idle", tx, 1'b1);
        bus_write(32'h4, 32'h8, 4'hF);
        read_chk("t4_clear", 32'h4, d);    check("t4_clear_lit", d, 32'h0801);

        // Divisor 0 acts as 1; push into a full FIFO while it pops
        bus_write(32'h8, 32'd0, 4'hF);
        read_chk("t4_div0", 32'h8, d);     check("t4_div0_lit", d, 32'h0);
        bus_write(32'hC, 32'd1, 4'hF);
        bus_write(32'h0, 32'h81, 4'hF);
        read_chk("t4_fullpop", 32'h4, d);  check("t4_fullpop_lit", d, 32'h0805);
        repeat (100) @(negedge clk);
        read_chk("t4_drained", 32'h4, d);  check("t4_drained_lit", d, 32'h2);

        // Interrupt around a frame, mid-frame divisor change
        bus_write(32'h8, 32'd2, 4'hF);
        bus_write(32'hC, 32'd3, 4'hF);
        repeat (3) @(negedge clk);
        check("t5_irq_idle", irq, 1'b1);
        bus_write(32'h0, 32'hFF, 4'hF);
        repeat (4) @(negedge clk);
        check("t5_irq_frame", irq, 1'b0);
        bus_write(32'h8, 32'd3, 4'hF);
        repeat (15) @(negedge clk);
        check("t5_irq_late_frame", irq, 1'b0);
        repeat (5) @(negedge clk);
        check("t5_irq_done", irq, 1'b1);
        bus_write(32'h0, 32'h12, 4'b0001);
        read_chk("t5_partial_sel", 32'h4, d); check("t5_partial_sel_lit", d, 32'h2);
        repeat (5) @(negedge clk);
        check("t5_tx_quiet", tx, 1'b1);
        check("t5_irq_hold", irq, 1'b1);

        // Reset in the middle of the data bits
        bus_write(32'h8, 32'd4, 4'hF);
        bus_write(32'h0, 32'h00, 4'hF);
        bus_write(32'h0, 32'h00, 4'hF);
        repeat (8) @(negedge clk);
        check("t6_tx_data", tx, 1'b0);
        read_chk("t6_status", 32'h4, d);   check("t6_status_lit", d, 32'h0104);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("t6_tx_reset", tx, 1'b1);
        read_chk("t6_flushed", 32'h4, d);  check("t6_flushed_lit", d, 32'h2);
        rst = 0;
        repeat (50) @(negedge clk);
        check("t6_tx_after", tx, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
